// File: rtl/boot_loader.sv
// Boot loader: streams a program image out of an SPI EEPROM (mode 0, sequential read)
// and writes it word-by-word into SRAM through the memory controller's boot port.
module boot_loader #(
  parameter logic [15:0] LAST_ADDR  = 16'hFFFF,
  parameter int unsigned SCK_DIV    = 2,
  parameter int unsigned ADDR_BYTES = 3,
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter int unsigned WR_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spiSDI,
  output logic        spiSCK,
  output logic        spiSCS,
  output logic        spiSDO,
  output logic [15:0] bootAddr,
  output logic [15:0] bootData,
  output logic        bootWr,
  output logic        bootEn,
  output logic        isBooted
);

  typedef enum logic [3:0] {
    IDLE, SELECT, CMD, ADDR, RD_HI, RD_LO, WRITE, DESELECT, DONE
  } stateT;

  localparam logic [15:0] LO_END   = 16'(SCK_DIV - 1);
  localparam logic [15:0] BIT_END  = 16'(2 * SCK_DIV - 1);
  localparam logic [15:0] WR_END   = 16'(WR_CYCLES - 1);
  localparam logic [15:0] ADDR_END = 16'(8 * ADDR_BYTES - 1);

  stateT       state, stateN;
  logic [15:0] ph, phN;
  logic [15:0] bitCnt, bitN;
  logic [7:0]  txShift, txN;
  logic [14:0] rxShift, rxN;
  logic        sckN, scsN, sdoN, wrN, bootedN;
  logic [15:0] addrN, dataN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ph       <= '0;
      bitCnt   <= '0;
      txShift  <= '0;
      rxShift  <= '0;
      spiSCK   <= 1'b0;
      spiSCS   <= 1'b1;
      spiSDO   <= 1'b0;
      bootAddr <= '0;
      bootData <= '0;
      bootWr   <= 1'b0;
      bootEn   <= 1'b0;
      isBooted <= 1'b0;
    end else begin
      state    <= stateN;
      ph       <= phN;
      bitCnt   <= bitN;
      txShift  <= txN;
      rxShift  <= rxN;
      spiSCK   <= sckN;
      spiSCS   <= scsN;
      spiSDO   <= sdoN;
      bootAddr <= addrN;
      bootData <= dataN;
      bootWr   <= wrN;
      bootEn   <= wrN;
      isBooted <= bootedN;
    end
  end

  always_comb begin
    stateN  = state;
    phN     = ph;
    bitN    = bitCnt;
    txN     = txShift;
    rxN     = rxShift;
    sckN    = spiSCK;
    scsN    = spiSCS;
    sdoN    = spiSDO;
    addrN   = bootAddr;
    dataN   = bootData;
    wrN     = 1'b0;
    bootedN = isBooted;

    case (state)
      IDLE: begin
        stateN = SELECT;
        scsN   = 1'b0;
        phN    = '0;
      end
      SELECT: begin
        if (ph == LO_END) begin
          stateN = CMD;
          phN    = '0;
          bitN   = '0;
          sdoN   = CMD_READ[7];
          txN    = {CMD_READ[6:0], 1'b0};
        end else begin
          phN = ph + 16'd1;
        end
      end
      CMD, ADDR, RD_HI, RD_LO: begin
        // One bit per 2*SCK_DIV clocks: SCK rises mid-bit; the edge that ends the
        // high phase samples SDI, drops SCK and launches the next SDO bit.
        phN = ph + 16'd1;
        if (ph == LO_END) sckN = 1'b1;
        if (ph == BIT_END) begin
          sckN = 1'b0;
          phN  = '0;
          bitN = bitCnt + 16'd1;
          sdoN = 1'b0;
          case (state)
            CMD: begin
              if (bitCnt == 16'd7) begin
                stateN = (ADDR_BYTES == 0) ? RD_HI : ADDR;
                bitN   = '0;
              end else begin
                sdoN = txShift[7];
                txN  = {txShift[6:0], 1'b0};
              end
            end
            ADDR: begin
              if (bitCnt == ADDR_END) begin
                stateN = RD_HI;
                bitN   = '0;
              end
            end
            RD_HI: begin
              rxN = {rxShift[13:0], spiSDI};
              if (bitCnt == 16'd7) begin
                stateN = RD_LO;
                bitN   = '0;
              end
            end
            RD_LO: begin
              rxN = {rxShift[13:0], spiSDI};
              if (bitCnt == 16'd7) begin
                stateN = WRITE;
                bitN   = '0;
                dataN  = {rxShift[14:0], spiSDI};
                wrN    = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        wrN = 1'b1;
        if (ph == WR_END) begin
          wrN = 1'b0;
          phN = '0;
          if (bootAddr == LAST_ADDR) begin
            stateN = DESELECT;
            scsN   = 1'b1;
          end else begin
            addrN  = bootAddr + 16'd1;
            stateN = RD_HI;
            bitN   = '0;
          end
        end else begin
          phN = ph + 16'd1;
        end
      end
      DESELECT: begin
        if (ph == LO_END) begin
          stateN  = DONE;
          bootedN = 1'b1;
        end else begin
          phN = ph + 16'd1;
        end
      end
      DONE: ;
      default: stateN = IDLE;
    endcase
  end

endmodule
